// File: rtl/spi_pkg.sv
// Shared constants and helpers for the multi-channel SPI slave.
// Synchronizer depth, the SPI mode sample-edge rule and byte/bit sizing.
package spi_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    // CPOL == CPHA (modes 0 and 3) samples on SCLK rise, modes 1 and 2 on fall.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

    function automatic int unsigned bytes_to_bits(input int unsigned nbytes);
        return nbytes * 8;
    endfunction

endpackage

// File: rtl/spi_slave_channel.sv
// One SPI slave channel: frame setup on CS fall, MSB-first shifting, frame completion
// with back-to-back reload, and abort detection on early CS rise.
module spi_slave_channel
    import spi_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned LEN_W     = 2,
    parameter int unsigned DW        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_fall,
    input  logic             cs_rise,
    input  logic             sclk_rise,
    input  logic             sclk_fall,
    input  logic             mosi,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [LEN_W-1:0] transaction_length,
    input  logic [DW-1:0]    tx_data,
    output logic             active,
    output logic             miso,
    output logic [DW-1:0]    rx_data,
    output logic             rx_valid,
    output logic             frame_err
);

    localparam int unsigned CW = $clog2(DW + 1);

    logic          active_q, active_d, cpol_q, cpol_d, cpha_q, cpha_d;
    logic          skip_q, skip_d, reload_q, reload_d;
    logic          rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
    logic [2:0]    nbytes_q, nbytes_d;
    logic [CW-1:0] cnt_q, cnt_d, nbits;
    logic [DW-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic [DW-1:0] rx_next, mask, msb_sel;
    logic          sample_edge, shift_edge;
    int unsigned   len_p1;

    assign nbits       = CW'(bytes_to_bits(32'(nbytes_q)));
    assign sample_edge = sample_on_rise(cpol_q, cpha_q) ? sclk_rise : sclk_fall;
    assign shift_edge  = sample_on_rise(cpol_q, cpha_q) ? sclk_fall : sclk_rise;

    always_comb begin
        for (int b = 0; b < DW; b++) begin
            mask[b]    = b < int'(nbits);
            msb_sel[b] = b == int'(nbits) - 1;
        end
    end

    always_comb begin
        active_d    = active_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        skip_d      = skip_q;
        reload_d    = reload_q;
        nbytes_d    = nbytes_q;
        cnt_d       = cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_next     = {rx_sr_q[DW-2:0], mosi};
        len_p1      = 32'(transaction_length) + 1;
        if (cs_fall) begin
            active_d = 1'b1;
            cpol_d   = cpol;
            cpha_d   = cpha;
            nbytes_d = 3'((len_p1 > MAX_BYTES) ? MAX_BYTES : len_p1);
            cnt_d    = '0;
            tx_sr_d  = tx_data;
            rx_sr_d  = '0;
            skip_d   = cpha;
            reload_d = 1'b0;
        end else if (cs_rise) begin
            active_d    = 1'b0;
            cnt_d       = '0;
            frame_err_d = active_q && (cnt_q != '0);
        end else if (active_q) begin
            if (sample_edge) begin
                rx_sr_d = rx_next;
                if (cnt_q == nbits - 1'b1) begin
                    cnt_d      = '0;
                    rx_data_d  = rx_next & mask;
                    rx_valid_d = 1'b1;
                    reload_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (shift_edge) begin
                // The shift edge after a completed frame starts the next one instead.
                if (reload_q) begin
                    tx_sr_d  = tx_data;
                    reload_d = 1'b0;
                    skip_d   = 1'b0;
                end else if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    tx_sr_d = {tx_sr_q[DW-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q    <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            skip_q      <= 1'b0;
            reload_q    <= 1'b0;
            nbytes_q    <= '0;
            cnt_q       <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            skip_q      <= skip_d;
            reload_q    <= reload_d;
            nbytes_q    <= nbytes_d;
            cnt_q       <= cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign active    = active_q;
    assign miso      = active_q & (|(tx_sr_q & msb_sel));
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/spi_multi_slave.sv
// Multi-channel SPI slave: shared SCLK/MOSI/CS synchronizers, one channel per chip
// select, lowest-index MISO mux and a sticky chip-select collision flag.
module spi_multi_slave
    import spi_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned LEN_W     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             SPI_SCLK,
    input  logic                             MOSI,
    input  logic [CHANNELS-1:0]              CS,
    output logic                             MISO,
    input  logic [LEN_W-1:0]                 transaction_length,
    input  logic                             CPOL,
    input  logic                             CPHA,
    input  logic [CHANNELS*8*MAX_BYTES-1:0]  tx_data,
    output logic [CHANNELS*8*MAX_BYTES-1:0]  rx_data,
    output logic [CHANNELS-1:0]              rx_valid,
    output logic [CHANNELS-1:0]              frame_err,
    output logic                             collision
);

    localparam int unsigned DW = bytes_to_bits(MAX_BYTES);

    logic [SYNC_DEPTH:0]                sclk_q;
    logic [SYNC_DEPTH-1:0]              mosi_q;
    logic [SYNC_DEPTH:0][CHANNELS-1:0]  cs_q;
    logic [CHANNELS-1:0]                cs_fall, cs_rise, active, miso_ch;
    logic                               sclk_rise, sclk_fall, multi, collision_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q      <= '0;
            mosi_q      <= '0;
            cs_q        <= '0;
            collision_q <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_DEPTH-1:0], SPI_SCLK};
            mosi_q <= {mosi_q[SYNC_DEPTH-2:0], MOSI};
            cs_q   <= {cs_q[SYNC_DEPTH-1:0], CS};
            if (multi) collision_q <= 1'b1;
        end
    end

    assign sclk_rise = sclk_q[SYNC_DEPTH-1] & ~sclk_q[SYNC_DEPTH];
    assign sclk_fall = ~sclk_q[SYNC_DEPTH-1] & sclk_q[SYNC_DEPTH];
    assign cs_fall   = ~cs_q[SYNC_DEPTH-1] & cs_q[SYNC_DEPTH];
    assign cs_rise   = cs_q[SYNC_DEPTH-1] & ~cs_q[SYNC_DEPTH];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        spi_slave_channel #(
            .MAX_BYTES (MAX_BYTES),
            .LEN_W     (LEN_W),
            .DW        (DW)
        ) u_ch (
            .clk                (clk),
            .rst                (rst),
            .cs_fall            (cs_fall[i]),
            .cs_rise            (cs_rise[i]),
            .sclk_rise          (sclk_rise),
            .sclk_fall          (sclk_fall),
            .mosi               (mosi_q[SYNC_DEPTH-1]),
            .cpol               (CPOL),
            .cpha               (CPHA),
            .transaction_length (transaction_length),
            .tx_data            (tx_data[i*DW +: DW]),
            .active             (active[i]),
            .miso               (miso_ch[i]),
            .rx_data            (rx_data[i*DW +: DW]),
            .rx_valid           (rx_valid[i]),
            .frame_err          (frame_err[i])
        );
    end

    // A channel only counts as selected once it has seen a fresh CS fall since reset.
    assign multi = |(active & (active - 1'b1));

    always_comb begin
        MISO = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (active[i]) MISO = miso_ch[i];
        end
    end

    assign collision = collision_q;

endmodule

// File: tb/tb_spi_multi_slave.sv
// Scoreboard bench for spi_multi_slave: directed SPI master transfers push expected
// rx/frame_err events; a monitor pops and compares them on every DUT pulse.
`timescale 1ns/1ps
module tb_spi_multi_slave;

    logic        clk = 1'b0;
    logic        rst, SPI_SCLK, MOSI, MISO, CPOL, CPHA, collision;
    logic [1:0]  CS, transaction_length, rx_valid, frame_err;
    logic [63:0] tx_data, rx_data;

    typedef struct packed {
        logic        err;
        logic [7:0]  ch;
        logic [31:0] data;
    } sb_t;

    sb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    spi_multi_slave #(
        .CHANNELS  (2),
        .MAX_BYTES (4),
        .LEN_W     (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .SPI_SCLK           (SPI_SCLK),
        .MOSI               (MOSI),
        .CS                 (CS),
        .MISO               (MISO),
        .transaction_length (transaction_length),
        .CPOL               (CPOL),
        .CPHA               (CPHA),
        .tx_data            (tx_data),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .frame_err          (frame_err),
        .collision          (collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_and_check(input logic err, input int ch);
        sb_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=err%0b/ch%0d required=no_event at %0t",
                     err, ch, $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_event", {23'd0, err, ch[7:0]}, {23'd0, e.err, e.ch});
            check("sb_rx_data", rx_data[ch*32 +: 32], e.data);
        end
    endtask

    // Monitor: every rx_valid / frame_err pulse must match the next expected event.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rx_valid[c]) pop_and_check(1'b0, c);
            if (frame_err[c]) pop_and_check(1'b1, c);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic half();
        wait_clk(8);
    endtask

    task automatic push(input logic err, input int ch, input logic [31:0] data);
        sb_t e;
        e.err  = err;
        e.ch   = ch[7:0];
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_mode(input logic cpol_v, input logic cpha_v, input logic [1:0] len);
        CPOL               = cpol_v;
        CPHA               = cpha_v;
        transaction_length = len;
        SPI_SCLK           = cpol_v;
        wait_clk(6);
    endtask

    task automatic xfer(input int nbits, input logic [31:0] mosi_w,
                        output logic [31:0] miso_w);
        miso_w = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!CPHA) begin
                MOSI = mosi_w[i];
                half();
                miso_w[i] = MISO;
                SPI_SCLK = ~CPOL;
                half();
                SPI_SCLK = CPOL;
            end else begin
                SPI_SCLK = ~CPOL;
                MOSI = mosi_w[i];
                half();
                miso_w[i] = MISO;
                SPI_SCLK = CPOL;
                half();
            end
        end
        half();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data_lo"}, rx_data[31:0], 32'h0);
        check({tag, "_rx_data_hi"}, rx_data[63:32], 32'h0);
        check({tag, "_pulses"}, {28'd0, rx_valid, frame_err}, 32'h0);
        check({tag, "_collision"}, {31'd0, collision}, 32'h0);
        check({tag, "_miso"}, {31'd0, MISO}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        rst = 1'b1;
        CS = 2'b11;
        SPI_SCLK = 1'b0;
        MOSI = 1'b0;
        CPOL = 1'b0;
        CPHA = 1'b0;
        transaction_length = 2'd0;
        tx_data = '0;
        wait_clk(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(6);

        // Mode 0, one byte on channel 0.
        set_mode(1'b0, 1'b0, 2'd0);
        tx_data[31:0] = 32'h0000_003C;
        CS = 2'b10;
        wait_clk(4);
        push(1'b0, 0, 32'h0000_00A5);
        xfer(8, 32'h0000_00A5, got);
        check("m0_miso", got, 32'h0000_003C);
        CS = 2'b11;
        wait_clk(6);

        // Modes 1..3, four bytes on channel 1.
        tx_data[63:32] = 32'h1234_5678;
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 2'd3);
            CS = 2'b01;
            wait_clk(4);
            push(1'b0, 1, 32'hDEAD_BEEF);
            xfer(32, 32'hDEAD_BEEF, got);
            check($sformatf("mode%0d_miso", m), got, 32'h1234_5678);
            CS = 2'b11;
            wait_clk(6);
        end

        // Back-to-back two-byte frames on channel 0 with CS held low.
        set_mode(1'b0, 1'b0, 2'd1);
        tx_data[31:0] = 32'h0000_5A5A;
        CS = 2'b10;
        wait_clk(4);
        push(1'b0, 0, 32'h0000_1234);
        xfer(16, 32'h0000_1234, got);
        check("b2b_miso0", got, 32'h0000_5A5A);
        push(1'b0, 0, 32'h0000_ABCD);
        xfer(16, 32'h0000_ABCD, got);
        check("b2b_miso1", got, 32'h0000_5A5A);
        CS = 2'b11;
        wait_clk(6);

        // CS[1] raised after 5 bits: frame_err, rx_data keeps DEADBEEF.
        set_mode(1'b0, 1'b0, 2'd0);
        CS = 2'b01;
        wait_clk(4);
        xfer(5, 32'h0000_001F, got);
        push(1'b1, 1, 32'hDEAD_BEEF);
        CS = 2'b11;
        wait_clk(6);
        CS = 2'b01;
        wait_clk(4);
        push(1'b0, 1, 32'h0000_0096);
        xfer(8, 32'h0000_0096, got);
        check("post_err_miso", got, 32'h0000_0078);
        CS = 2'b11;
        wait_clk(6);

        // Both chip selects low: collision, MISO from channel 0 (bit7=1 vs ch1 bit7=0).
        tx_data[31:0] = 32'h0000_0080;
        CS = 2'b00;
        wait_clk(6);
        check("coll_set", {31'd0, collision}, 32'h1);
        check("coll_miso", {31'd0, MISO}, 32'h1);
        CS = 2'b11;
        wait_clk(6);
        check("coll_sticky", {31'd0, collision}, 32'h1);
        check("idle_miso", {31'd0, MISO}, 32'h0);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        check("coll_cleared", {31'd0, collision}, 32'h0);

        // Reset mid-frame, then bits with CS still low must be ignored.
        tx_data[31:0] = 32'h0000_003C;
        CS = 2'b10;
        wait_clk(4);
        xfer(4, 32'h0000_000A, got);
        rst = 1'b1;
        wait_clk(3);
        check_reset_outputs("midrst");
        rst = 1'b0;
        wait_clk(4);
        xfer(8, 32'h0000_00FF, got);
        CS = 2'b11;
        wait_clk(6);
        CS = 2'b10;
        wait_clk(4);
        push(1'b0, 0, 32'h0000_005C);
        xfer(8, 32'h0000_005C, got);
        check("after_rst_miso", got, 32'h0000_003C);
        CS = 2'b11;
        wait_clk(20);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
